// File: rtl/mul_vec_pkg.sv
// Shared types and defaults for the sequential multi-limb vector multiplier.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package mul_vec_pkg;

    localparam int DEF_LIMB_W  = 16;
    localparam int DEF_N_LIMBS = 2;

    typedef logic [DEF_LIMB_W-1:0]   limb_t;
    typedef logic [2*DEF_LIMB_W-1:0] dlimb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width that stays at least one bit wide, even when only one value is needed.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/limb_mac.sv
// One limb-by-limb partial product, shifted by its limb offset and added into the accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_out.
module limb_mac
    import mul_vec_pkg::*;
#(
    parameter int LIMB_W  = DEF_LIMB_W,
    parameter int N_LIMBS = DEF_N_LIMBS,
    parameter int OFF_W   = idx_w(2*N_LIMBS)
) (
    input  logic [LIMB_W-1:0]           a_limb,
    input  logic [LIMB_W-1:0]           b_limb,
    input  logic [OFF_W-1:0]            off,
    input  logic [2*N_LIMBS*LIMB_W-1:0] acc_in,
    output logic [2*N_LIMBS*LIMB_W-1:0] acc_out
);

    localparam int ACC_W = 2*N_LIMBS*LIMB_W;

    logic [2*LIMB_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    // Full-width product; zero-extending both operands keeps the multiply unsigned.
    assign prod     = {{LIMB_W{1'b0}}, a_limb} * {{LIMB_W{1'b0}}, b_limb};
    assign prod_ext = ACC_W'(prod);

    // The highest offset is 2*N_LIMBS-2, so the shifted product always fits the accumulator.
    assign acc_out  = acc_in + (prod_ext << (int'(off) * LIMB_W));

endmodule

// File: rtl/mul_vec_seq.sv
// Sequential schoolbook multiplier: N_LIMBS x N_LIMBS limbs into a 2*N_LIMBS-limb product, one MAC per cycle.
// Latency: N_LIMBS*N_LIMBS+1 cycles from the accept edge (with MUL_VEC_ZERO_SKIP_EN, zero rows of A cost one cycle).
// Backpressure: one transaction in flight; y and out_valid hold until out_ready, in_ready stays low meanwhile.
module mul_vec_seq
    import mul_vec_pkg::*;
#(
    parameter int LIMB_W  = DEF_LIMB_W,
    parameter int N_LIMBS = DEF_N_LIMBS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_LIMBS*LIMB_W-1:0]     a,
    input  logic [N_LIMBS*LIMB_W-1:0]     b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*N_LIMBS*LIMB_W-1:0]   y,
    output logic                          busy
);

    localparam int OP_W  = N_LIMBS*LIMB_W;
    localparam int ACC_W = 2*OP_W;
    localparam int IW    = idx_w(N_LIMBS);
    localparam int OFF_W = idx_w(2*N_LIMBS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_LIMBS-1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   a_q, b_q;
    logic [ACC_W-1:0]  acc_q, acc_mac, acc_step, y_q;
    logic [IW-1:0]     i_q, j_q;
    logic [LIMB_W-1:0] a_limb, b_limb;
    logic [OFF_W-1:0]  off;
    logic              row_skip;
    logic              last_step;

    assign a_limb = a_q[int'(i_q)*LIMB_W +: LIMB_W];
    assign b_limb = b_q[int'(j_q)*LIMB_W +: LIMB_W];
    assign off    = OFF_W'(i_q) + OFF_W'(j_q);

    limb_mac #(
        .LIMB_W  (LIMB_W),
        .N_LIMBS (N_LIMBS),
        .OFF_W   (OFF_W)
    ) u_mac (
        .a_limb  (a_limb),
        .b_limb  (b_limb),
        .off     (off),
        .acc_in  (acc_q),
        .acc_out (acc_mac)
    );

    // A row whose A limb is zero contributes nothing, so it can be retired in a single cycle.
`ifdef MUL_VEC_ZERO_SKIP_EN
    assign row_skip = (state_q == MUL) && (j_q == '0) && (a_limb == '0);
`else
    assign row_skip = 1'b0;
`endif

    assign last_step = (i_q == LAST_IDX) && (row_skip || (j_q == LAST_IDX));
    assign acc_step  = row_skip ? acc_q : acc_mac;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, finish after the last limb pair, release on the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = MUL;
            MUL:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == MUL);
        out_valid = (state_q == DONE);
    end

    assign y = y_q;

    // Operand capture, limb counters, accumulator and product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            y_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                MUL: begin
                    acc_q <= acc_step;
                    if (last_step) begin
                        y_q <= acc_step;
                        i_q <= '0;
                        j_q <= '0;
                    end else if (row_skip || (j_q == LAST_IDX)) begin
                        i_q <= i_q + 1'b1;
                        j_q <= '0;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_vec_seq.sv
// Self-checking bench for mul_vec_seq at LIMB_W=16, N_LIMBS=2 (honours MUL_VEC_ZERO_SKIP_EN for latency).
// Latency: expected per transaction from a small row model; products from a plain 64-bit multiply.
// Backpressure: holds out_ready low for a table-given number of cycles before releasing each result.
module tb_mul_vec_seq;

    localparam int LW = 16;
    localparam int NL = 2;
`ifdef MUL_VEC_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [NL*LW-1:0]     a = '0;
    logic [NL*LW-1:0]     b = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [2*NL*LW-1:0]   y;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] y;
        int          hold;
    } vec_t;

    typedef struct {
        logic [63:0] y;
        int          lat;
    } exp_t;

    vec_t tbl[6];
    exp_t sb[$];

    mul_vec_seq #(.LIMB_W(LW), .N_LIMBS(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Edges from presenting operands (accept edge included) until out_valid is visible.
    function automatic int exp_lat(input logic [31:0] av);
        int l = 1;
        for (int i = 0; i < NL; i++) begin
            l += (ZS && (av[i*LW +: LW] == '0)) ? 1 : NL;
        end
        return l;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_y"},         y,              64'd0);
    endtask

    // Called at #1 after a clock edge with the DUT idle.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] yexp, input int hold);
        exp_t        e;
        int          lat;
        logic [63:0] y_hold;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        e.y   = yexp;
        e.lat = exp_lat(av);
        sb.push_back(e);
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        while (!out_valid && lat < 50) begin
            chk("busy_mul", 64'(busy), 64'd1);
            chk("in_ready_mul", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("timeout_out_valid", 64'(out_valid), 64'd1);
        e = sb.pop_front();
        if (!out_valid) return;
        chk("latency", 64'(lat), 64'(e.lat));
        chk("y", y, e.y);
        y_hold = y;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("y_stable", y, y_hold);
            chk("out_valid_held", 64'(out_valid), 64'd1);
            chk("in_ready_done", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 64'(out_valid), 64'd0);
        chk("in_ready_back", 64'(in_ready), 64'd1);
        chk("y_keep", y, y_hold);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] av, bv;

        tbl[0] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 3};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0};
        tbl[2] = '{32'h0000_0001, 32'h0000_0007, 64'h0000_0000_0000_0007, 10};
        tbl[3] = '{32'h0003_0002, 32'h0005_0004, 64'h0000_000F_0016_0008, 1};
        tbl[4] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 0};
        tbl[5] = '{32'h0001_0000, 32'h1234_5678, 64'h0000_1234_5678_0000, 0};

        // Reset state, asserted from time zero.
        #12;
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("idle");

        // out_ready while idle must not disturb anything.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_reset_vals("idle_oready");

        for (int t = 0; t < 6; t++) begin
            run_op(tbl[t].a, tbl[t].b, tbl[t].y, tbl[t].hold);
        end

        // Reset on the second MUL cycle discards the transaction.
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("no_out_after_rst", 64'(out_valid), 64'd0);
        end
        run_op(32'h0003_0002, 32'h0005_0004, 64'h0000_000F_0016_0008, 0);

        // Pseudo-random operands, some with zero limbs in A.
        for (int r = 0; r < 8; r++) begin
            av = $urandom;
            bv = $urandom;
            if (r[0]) av[15:0] = '0;
            if (r == 4) av[31:16] = '0;
            run_op(av, bv, {32'd0, av} * {32'd0, bv}, r % 3);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
